// File: rtl/delay_pipe_rr_sched.sv
// Round-robin front end for a shared fixed-latency delay pipe.
// Tracks requester IDs alongside the pipe and steers results back.
module delay_pipe_rr_sched #(
  parameter int R       = 4,
  parameter int N       = 5,
  parameter int W       = 32,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [R-1:0]   req_vld,
  input  logic [R*W-1:0] req_dat,
  output logic [R-1:0]   req_rdy,
  output logic [W-1:0]   pipe_in,
  output logic           pipe_in_vld,
  input  logic [W-1:0]   pipe_out,
  input  logic           pipe_out_vld,
  output logic [R-1:0]   rsp_vld,
  output logic [W-1:0]   rsp_dat,
  output logic           busy,
  output logic           err_r
);

  localparam int PW = $clog2(R);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST = PW'(R - 1);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] g;
  logic          any_g;
  logic [R-1:0]  elig;
  logic [CW-1:0] cnt_r [R];
  logic [PW-1:0] id_r [N];
  logic [N-1:0]  tv_r;

  always_comb begin
    for (int r = 0; r < R; r++) begin
      elig[r] = req_vld[r] && (cnt_r[r] < MAXC);
    end
  end

  // Scan from farthest to nearest so the slot closest to ptr_r wins.
  always_comb begin
    int idx;
    g     = '0;
    any_g = 1'b0;
    for (int k = R - 1; k >= 0; k--) begin
      idx = int'(ptr_r) + k;
      if (idx >= R) idx = idx - R;
      if (elig[idx]) begin
        g     = PW'(idx);
        any_g = 1'b1;
      end
    end
  end

  assign req_rdy     = any_g ? (R'(1) << g) : '0;
  assign pipe_in     = req_dat[int'(g)*W +: W];
  assign pipe_in_vld = any_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (any_g) begin
      ptr_r <= (g == LAST) ? '0 : g + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_r <= '0;
    end else begin
      tv_r[0] <= any_g;
      for (int i = 1; i < N; i++) begin
        tv_r[i] <= tv_r[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    id_r[0] <= g;
    for (int i = 1; i < N; i++) begin
      id_r[i] <= id_r[i-1];
    end
  end

  always_comb begin
    for (int r = 0; r < R; r++) begin
      rsp_vld[r] = pipe_out_vld && tv_r[N-1] &&
                   (id_r[N-1] == PW'(r));
    end
  end

  assign rsp_dat = pipe_out;

  // Simultaneous grant and return leave the count unchanged.
  for (genvar r = 0; r < R; r++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r[r] <= '0;
      end else if (req_rdy[r] && !rsp_vld[r]) begin
        cnt_r[r] <= cnt_r[r] + 1'b1;
      end else if (!req_rdy[r] && rsp_vld[r]) begin
        cnt_r[r] <= cnt_r[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < R; r++) begin
      busy = busy | (cnt_r[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (pipe_out_vld != tv_r[N-1]) begin
      err_r <= 1'b1;
    end
  end

endmodule
